// File: rtl/clock_set_ctrl.sv
// Time-setting controller: captures live time, edits h/m/s in BCD, commits via set_time.
// Optional CLKSET_TIMEOUT_EN discards an idle edit after TIMEOUT_CYCLES cycles.
module clock_set_ctrl #(
    parameter int TIMEOUT_CYCLES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        mode_24h,
    input  logic [19:0] cur_time,
    output logic [19:0] stime,
    output logic        set_time,
    output logic        editing,
    output logic [1:0]  edit_field
);

    typedef enum logic [2:0] {
        RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] stime_q, stime_d;
    logic        set_time_q, set_time_d;
    logic        editing_q, editing_d;
    logic [1:0]  edit_field_q, edit_field_d;
    logic        in_edit;
    logic        any_btn;
    logic        step;
    logic        timeout;
    logic [5:0]  hrs;

    assign in_edit = (state_q == EDIT_H) || (state_q == EDIT_M) ||
                     (state_q == EDIT_S);
    assign any_btn = btn_mode | btn_inc | btn_dec;
    assign step    = btn_inc ^ btn_dec;

    // Map a BCD hour 00..23 onto the 12 h range 01..12.
    function automatic logic [5:0] norm12(input logic [5:0] h);
        logic [5:0] r;
        r = h;
        if (h == 6'h00)
            r = 6'h12;
        else if (h >= 6'h13 && h <= 6'h19)
            r = {2'd0, h[3:0] - 4'd2};
        else if (h == 6'h20 || h == 6'h21)
            r = {2'd0, h[3:0] + 4'd8};
        else if (h == 6'h22 || h == 6'h23)
            r = {2'd1, h[3:0] - 4'd2};
        return r;
    endfunction

    function automatic logic [5:0] hour_step(input logic [5:0] h,
                                             input logic up,
                                             input logic h24);
        logic [5:0] r;
        if (up) begin
            if (h24 && h == 6'h23)
                r = 6'h00;
            else if (!h24 && h == 6'h12)
                r = 6'h01;
            else if (h[3:0] == 4'd9)
                r = {h[5:4] + 2'd1, 4'd0};
            else
                r = {h[5:4], h[3:0] + 4'd1};
        end else begin
            if (h24 && h == 6'h00)
                r = 6'h23;
            else if (!h24 && h == 6'h01)
                r = 6'h12;
            else if (h[3:0] == 4'd0)
                r = {h[5:4] - 2'd1, 4'd9};
            else
                r = {h[5:4], h[3:0] - 4'd1};
        end
        return r;
    endfunction

    function automatic logic [6:0] ms_step(input logic [6:0] v,
                                           input logic up);
        logic [6:0] r;
        if (up) begin
            if (v[3:0] == 4'd9)
                r = {(v[6:4] == 3'd5) ? 3'd0 : v[6:4] + 3'd1, 4'd0};
            else
                r = {v[6:4], v[3:0] + 4'd1};
        end else begin
            if (v[3:0] == 4'd0)
                r = {(v[6:4] == 3'd0) ? 3'd5 : v[6:4] - 3'd1, 4'd9};
            else
                r = {v[6:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

`ifdef CLKSET_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    logic [IW-1:0] idle_q, idle_d;

    always_comb begin
        idle_d  = '0;
        timeout = 1'b0;
        if (in_edit && !any_btn) begin
            if (idle_q == IW'(TIMEOUT_CYCLES - 1))
                timeout = 1'b1;
            else
                idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            stime_q      <= '0;
            set_time_q   <= 1'b0;
            editing_q    <= 1'b0;
            edit_field_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            stime_q      <= stime_d;
            set_time_q   <= set_time_d;
            editing_q    <= editing_d;
            edit_field_q <= edit_field_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:    if (btn_mode) state_d = EDIT_H;
            EDIT_H: if (btn_mode) state_d = EDIT_M;
                    else if (timeout) state_d = RUN;
            EDIT_M: if (btn_mode) state_d = EDIT_S;
                    else if (timeout) state_d = RUN;
            EDIT_S: if (btn_mode) state_d = COMMIT;
                    else if (timeout) state_d = RUN;
            COMMIT: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Hours are re-ranged every edit cycle so a 12/24 h switch takes effect.
    always_comb begin
        stime_d = stime_q;
        hrs     = mode_24h ? stime_q[19:14] : norm12(stime_q[19:14]);
        if (state_q == RUN && btn_mode) begin
            stime_d = {mode_24h ? cur_time[19:14] : norm12(cur_time[19:14]),
                       cur_time[13:0]};
        end else if (in_edit) begin
            stime_d[19:14] = hrs;
            if (!btn_mode && step) begin
                if (state_q == EDIT_H)
                    stime_d[19:14] = hour_step(hrs, btn_inc, mode_24h);
                else if (state_q == EDIT_M)
                    stime_d[13:7] = ms_step(stime_q[13:7], btn_inc);
                else
                    stime_d[6:0] = ms_step(stime_q[6:0], btn_inc);
            end
        end
    end

    always_comb begin
        set_time_d   = (state_d == COMMIT);
        editing_d    = (state_d == EDIT_H) || (state_d == EDIT_M) ||
                       (state_d == EDIT_S);
        edit_field_d = 2'd0;
        unique case (state_d)
            EDIT_H:  edit_field_d = 2'd1;
            EDIT_M:  edit_field_d = 2'd2;
            EDIT_S:  edit_field_d = 2'd3;
            default: edit_field_d = 2'd0;
        endcase
    end

    assign stime      = stime_q;
    assign set_time   = set_time_q;
    assign editing    = editing_q;
    assign edit_field = edit_field_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random stimulus
// checked against an integer-arithmetic reference model.
module tb_clock_set_ctrl;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_mode, btn_inc, btn_dec;
    logic        mode_24h;
    logic [19:0] cur_time;
    logic [19:0] stime;
    logic        set_time;
    logic        editing;
    logic [1:0]  edit_field;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: stage 0 run, 1..3 edit h/m/s, 4 commit
    int m_st, m_hh, m_mm, m_ss, m_idle;

    clock_set_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .mode_24h   (mode_24h),
        .cur_time   (cur_time),
        .stime      (stime),
        .set_time   (set_time),
        .editing    (editing),
        .edit_field (edit_field)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] bcd(input int h, input int m, input int s);
        logic [19:0] r;
        r[19:18] = 2'(h / 10);
        r[17:14] = 4'(h % 10);
        r[13:11] = 3'(m / 10);
        r[10:7]  = 4'(m % 10);
        r[6:4]   = 3'(s / 10);
        r[3:0]   = 4'(s % 10);
        return r;
    endfunction

    function automatic int n12(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_clk();
        int d;
        if (rst) begin
            m_st = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_idle = 0;
        end else if (m_st == 0) begin
            m_idle = 0;
            if (btn_mode) begin
                m_hh = int'(cur_time[19:18]) * 10 + int'(cur_time[17:14]);
                m_mm = int'(cur_time[13:11]) * 10 + int'(cur_time[10:7]);
                m_ss = int'(cur_time[6:4]) * 10 + int'(cur_time[3:0]);
                if (!mode_24h) m_hh = n12(m_hh);
                m_st = 1;
            end
        end else if (m_st == 4) begin
            m_st = 0;
        end else begin
            if (!mode_24h) m_hh = n12(m_hh);
            if (btn_mode) begin
                m_st = m_st + 1;
            end else if (btn_inc != btn_dec) begin
                d = btn_inc ? 1 : -1;
                if (m_st == 1)
                    m_hh = mode_24h ? (m_hh + d + 24) % 24
                                    : ((m_hh - 1 + d + 12) % 12) + 1;
                else if (m_st == 2)
                    m_mm = (m_mm + d + 60) % 60;
                else
                    m_ss = (m_ss + d + 60) % 60;
            end
`ifdef CLKSET_TIMEOUT_EN
            if (btn_mode || btn_inc || btn_dec) begin
                m_idle = 0;
            end else begin
                m_idle = m_idle + 1;
                if (m_idle == TO) begin
                    m_st = 0;
                    m_idle = 0;
                end
            end
`endif
        end
    endtask

    task automatic step(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        @(posedge clk);
        model_clk();
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0);
        step(1, 1, 0);
        rst = 1'b0;
        n_checks++;
        if (stime !== 20'h0) begin
            n_fail++; $display("FAIL reset_stime got %h want 00000", stime);
        end
        n_checks++;
        if (set_time !== 1'b0) begin
            n_fail++; $display("FAIL reset_set_time got %b want 0", set_time);
        end
        n_checks++;
        if (editing !== 1'b0) begin
            n_fail++; $display("FAIL reset_editing got %b want 0", editing);
        end
        n_checks++;
        if (edit_field !== 2'd0) begin
            n_fail++; $display("FAIL reset_field got %0d want 0", edit_field);
        end
    endtask

    task automatic test_capture();
        mode_24h = 1'b1;
        cur_time = bcd(14, 35, 7);
        step(0, 1, 0);
        n_checks++;
        if (editing !== 1'b0) begin
            n_fail++; $display("FAIL run_inc_ignored got editing %b want 0", editing);
        end
        step(1, 0, 0);
        cur_time = bcd(3, 3, 3);
        n_checks++;
        if (stime !== bcd(14, 35, 7)) begin
            n_fail++; $display("FAIL capture_stime got %h want %h", stime, bcd(14, 35, 7));
        end
        n_checks++;
        if (edit_field !== 2'd1 || editing !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_flags got field %0d edit %b want 1 1", edit_field, editing);
        end
    endtask

    task automatic test_hour_wrap();
        repeat (9) step(0, 1, 0);
        n_checks++;
        if (stime !== bcd(23, 35, 7)) begin
            n_fail++; $display("FAIL hour_to_23 got %h want %h", stime, bcd(23, 35, 7));
        end
        step(0, 1, 0);
        n_checks++;
        if (stime !== bcd(0, 35, 7)) begin
            n_fail++; $display("FAIL hour24_wrap_up got %h want %h", stime, bcd(0, 35, 7));
        end
        mode_24h = 1'b0;
        step(0, 0, 0);
        n_checks++;
        if (stime !== bcd(12, 35, 7)) begin
            n_fail++; $display("FAIL renorm_12h got %h want %h", stime, bcd(12, 35, 7));
        end
        step(0, 1, 0);
        n_checks++;
        if (stime !== bcd(1, 35, 7)) begin
            n_fail++; $display("FAIL hour12_wrap_up got %h want %h", stime, bcd(1, 35, 7));
        end
        step(0, 0, 1);
        n_checks++;
        if (stime !== bcd(12, 35, 7)) begin
            n_fail++; $display("FAIL hour12_wrap_dn got %h want %h", stime, bcd(12, 35, 7));
        end
    endtask

    task automatic test_min_sec_wrap();
        step(1, 0, 0);
        repeat (24) step(0, 1, 0);
        n_checks++;
        if (stime !== bcd(12, 59, 7) || edit_field !== 2'd2) begin
            n_fail++; $display("FAIL min_to_59 got %h f%0d want %h f2", stime, edit_field, bcd(12, 59, 7));
        end
        step(0, 1, 0);
        n_checks++;
        if (stime !== bcd(12, 0, 7)) begin
            n_fail++; $display("FAIL min_wrap_up got %h want %h", stime, bcd(12, 0, 7));
        end
        step(1, 0, 0);
        repeat (7) step(0, 0, 1);
        step(0, 0, 1);
        n_checks++;
        if (stime !== bcd(12, 0, 59) || edit_field !== 2'd3) begin
            n_fail++; $display("FAIL sec_wrap_dn got %h f%0d want %h f3", stime, edit_field, bcd(12, 0, 59));
        end
        step(1, 0, 0);
        n_checks++;
        if (set_time !== 1'b1 || editing !== 1'b0 || edit_field !== 2'd0) begin
            n_fail++;
            $display("FAIL commit_flags got st %b ed %b f %0d want 1 0 0", set_time, editing, edit_field);
        end
        step(1, 0, 0);
        n_checks++;
        if (set_time !== 1'b0 || editing !== 1'b0) begin
            n_fail++; $display("FAIL commit_mode_ignored got st %b ed %b want 0 0", set_time, editing);
        end
    endtask

    task automatic test_full_pass();
        int pulses;
        mode_24h = 1'b1;
        cur_time = bcd(9, 15, 30);
        step(1, 0, 0);
        step(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        n_checks++;
        if (set_time !== 1'b0) begin
            n_fail++; $display("FAIL pass_early_strobe got %b want 0", set_time);
        end
        step(1, 0, 0);
        n_checks++;
        if (set_time !== 1'b1 || stime !== bcd(10, 14, 30)) begin
            n_fail++; $display("FAIL pass_commit got st %b %h want 1 %h", set_time, stime, bcd(10, 14, 30));
        end
        pulses = 0;
        repeat (4) begin
            step(0, 0, 0);
            if (set_time) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || editing !== 1'b0 || stime !== bcd(10, 14, 30)) begin
            n_fail++;
            $display("FAIL pass_after got pulses %0d ed %b %h want 0 0 %h", pulses, editing, stime, bcd(10, 14, 30));
        end
    endtask

    task automatic test_simultaneous();
        mode_24h = 1'b0;
        cur_time = bcd(18, 0, 0);
        step(1, 0, 0);
        n_checks++;
        if (stime !== bcd(6, 0, 0)) begin
            n_fail++; $display("FAIL norm_18 got %h want %h", stime, bcd(6, 0, 0));
        end
        step(0, 1, 1);
        n_checks++;
        if (stime !== bcd(6, 0, 0)) begin
            n_fail++; $display("FAIL inc_dec_same got %h want %h", stime, bcd(6, 0, 0));
        end
        step(1, 1, 0);
        n_checks++;
        if (stime !== bcd(6, 0, 0) || edit_field !== 2'd2) begin
            n_fail++; $display("FAIL mode_wins got %h f%0d want %h f2", stime, edit_field, bcd(6, 0, 0));
        end
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic test_rst_mid_edit();
        int pulses;
        mode_24h = 1'b1;
        cur_time = bcd(21, 45, 50);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        rst = 1'b1;
        step(1, 0, 0);
        rst = 1'b0;
        pulses = set_time ? 1 : 0;
        step(0, 0, 0);
        if (set_time) pulses++;
        n_checks++;
        if (stime !== 20'h0 || editing !== 1'b0 || edit_field !== 2'd0 || pulses !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_edit got %h ed %b f %0d pulses %0d want 00000 0 0 0", stime, editing, edit_field, pulses);
        end
    endtask

`ifdef CLKSET_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        int pulses;
        mode_24h = 1'b1;
        cur_time = bcd(7, 8, 9);
        step(1, 0, 0);
        step(1, 0, 0);
        cyc = 0;
        pulses = 0;
        while (editing && cyc < 60) begin
            step(0, 0, 0);
            cyc++;
            if (set_time) pulses++;
        end
        n_checks++;
        if (cyc != TO || pulses != 0 || stime !== bcd(7, 8, 9)) begin
            n_fail++;
            $display("FAIL timeout got cycles %0d pulses %0d %h want %0d 0 %h", cyc, pulses, stime, TO, bcd(7, 8, 9));
        end
    endtask
`endif

    task automatic test_random();
        logic [19:0] exp_t;
        int r;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 7) == 0)
                cur_time = bcd($urandom_range(0, 23), $urandom_range(0, 59),
                               $urandom_range(0, 59));
            if ($urandom_range(0, 24) == 0) mode_24h = ~mode_24h;
            rst = ($urandom_range(0, 149) == 0);
            r = $urandom_range(0, 15);
            step(r == 0, r inside {[1:6], 13}, r inside {[7:13]});
            rst = 1'b0;
            exp_t = bcd(m_hh, m_mm, m_ss);
            n_checks++;
            if (stime !== exp_t || set_time !== (m_st == 4) ||
                editing !== (m_st inside {[1:3]}) ||
                edit_field !== ((m_st inside {[1:3]}) ? 2'(m_st) : 2'd0)) begin
                n_fail++;
                $display("FAIL random_%0d got %h st %b ed %b f %0d want %h stage %0d",
                         k, stime, set_time, editing, edit_field, exp_t, m_st);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        mode_24h = 1'b1;
        cur_time = '0;
        m_st = 0; m_hh = 0; m_mm = 0; m_ss = 0; m_idle = 0;
        test_reset();
        test_capture();
        test_hour_wrap();
        test_min_sec_wrap();
        test_full_pass();
        test_simultaneous();
        test_rst_mid_edit();
`ifdef CLKSET_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven time-setting controller for the digital clock. It captures the live time into a shadow register and steps the user through hour, minute and second editing with increment/decrement buttons. On completion it drives the BCD counter chain's `set_time` and `stime` inputs with a single-cycle commit pulse. It sits between the debounced button front-end and the timekeeping datapath.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 20: idle `clk` cycles before an abandoned edit is discarded. Only used when `CLKSET_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  single-cycle debounced pulse that advances the edit stage.
- `btn_inc`  in  1  single-cycle pulse that increments the selected field.
- `btn_dec`  in  1  single-cycle pulse that decrements the selected field.
- `mode_24h`  in  1  1 = 24 h hour range, 0 = 12 h hour range.
- `cur_time`  in  20  live time, packed BCD: [3:0] s0, [6:4] s1, [10:7] m0, [13:11] m1, [17:14] h0, [19:18] h1.
- `stime`  out  20  value to load into the counters, same packing; driven from the shadow register.
- `set_time`  out  1  single-cycle load strobe for the counter chain.
- `editing`  out  1  high in any EDIT state, for display blink gating.
- `edit_field`  out  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds.

## Operation
- States: RUN, EDIT_H, EDIT_M, EDIT_S, COMMIT.
- RUN:
  - `btn_mode` loads the shadow register from `cur_time`, normalized to the current hour range, then goes to EDIT_H.
  - `btn_inc` and `btn_dec` are ignored.
- EDIT_H, EDIT_M, EDIT_S:
  - `btn_inc` and `btn_dec` modify the selected field by ±1 with wrap.
  - `btn_mode` advances EDIT_H→EDIT_M→EDIT_S→COMMIT.
- COMMIT: lasts exactly one cycle with `set_time`=1, then returns to RUN.
- All field arithmetic is done directly in BCD. No binary intermediate leaves the block.
- Hours:
  - 24 h: range 00..23; 23+1→00, 00−1→23.
  - 12 h: range 01..12; 12+1→01, 01−1→12.
- Minutes and seconds: range 00..59; 59+1→00, 00−1→59. The carry from a units digit never propagates into another field.
- Normalization on capture in 12 h mode:
  - hour 00→12.
  - hours 13..23→hour−12.
  - Other fields are taken as-is.
- Boundary and simultaneous events:
  - `btn_inc` and `btn_dec` in the same cycle: no change.
  - `btn_mode` in the same cycle as `btn_inc` or `btn_dec`: mode wins and the increment/decrement is dropped.
  - A `mode_24h` change during editing renormalizes the shadow hours on the next cycle.
  - `rst` in any state: next state RUN, shadow register cleared, edit discarded, no `set_time` pulse.
- `stime` holds the last shadow value in RUN. It is stable throughout COMMIT.

## Timing
- Reset values:
  - state = RUN
  - `set_time` = 0
  - `editing` = 0
  - `edit_field` = 0
  - `stime` = 20'h0
  - idle counter = 0
- All outputs are registered.
- Field update: a button in cycle N updates `stime` in cycle N+1.
- Commit latency:
  - `btn_mode` in EDIT_S at cycle N gives `set_time`=1 at N+1 only.
  - `editing` falls at N+1. `edit_field`=0 at N+1.
- `btn_mode` in COMMIT is ignored. Buttons are not queued.
- Capture: `btn_mode` in RUN at cycle N latches `cur_time` sampled at N. `editing`=1 and `edit_field`=1 from N+1.

## Configuration
- Macro: `CLKSET_TIMEOUT_EN`.
- Defined:
  - An idle counter runs in the EDIT states and resets on any button pulse.
  - When it reaches `TIMEOUT_CYCLES`, the next state is RUN with no `set_time` pulse.
  - The shadow register keeps its value, so `stime` keeps its value.
- Undefined: no counter exists, and the EDIT states persist indefinitely.

## Test plan
- Reset, then `cur_time`=14:35:07 with `mode_24h`=1, then `btn_mode` → `stime`=14:35:07, `edit_field`=1, `editing`=1 one cycle later.
- In EDIT_H at 23, `btn_inc` ×1 → hours 00. Repeat with `mode_24h`=0 at 12, `btn_inc` → 01. Then `btn_dec` → 12.
- In EDIT_M at 59, `btn_inc` → 00 with hours unchanged. In EDIT_S at 00, `btn_dec` → 59 with minutes unchanged.
- Full pass: capture 09:15:30, then +1 hour, −1 minute, mode ×3 → exactly one cycle of `set_time`=1 with `stime`=10:14:30, followed by RUN.
- Capture 18:00:00 with `mode_24h`=0 → shadow 06:00:00. Same-cycle `btn_inc`+`btn_dec` → no change. `btn_mode`+`btn_inc` → advances to EDIT_M with hours unchanged.
- `CLKSET_TIMEOUT_EN` defined with `TIMEOUT_CYCLES`=20: enter EDIT_M and stay idle 20 cycles → RUN with `set_time` never asserted. `rst` mid-EDIT_S → RUN, `stime`=0, no strobe.
